// File: rtl/ysyx_25020047_mem_pkg.sv
// Shared definitions for the IFU/LSU memory-port arbiter: FSM state and
// owner encodings, the default abort limit and the byte-strobe patterns.
package ysyx_25020047_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_e;

    // Cycles allowed in REQ+WAIT before an access is abandoned.
    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    // Strobe patterns before shifting by addr[1:0] (sb/sh) or used as-is (sw).
    localparam logic [3:0] WMASK_BYTE = 4'b0001;
    localparam logic [3:0] WMASK_HALF = 4'b0011;
    localparam logic [3:0] WMASK_WORD = 4'b1111;

endpackage

// File: rtl/ysyx_25020047_mem_arb_timer.sv
// Abort timer for the memory-port arbiter: clears when a request is
// accepted, counts every cycle the access is in flight and flags when the
// count reaches TIMEOUT_CYCLES. Only built with YSYX_25020047_MEM_ARB_TIMEOUT_EN.
module ysyx_25020047_mem_arb_timer
    import ysyx_25020047_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    // Count in-flight cycles; hold at the limit so the flag stays stable.
    always_ff @(posedge clk) begin
        // NOTE: registers take <= so every flop samples pre-edge values;
        // a blocking assignment here would create ordering races in simulation.
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (active && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/ysyx_25020047_mem_arb.sv
// Two-requester memory-port controller. Serialises IFU fetches and LSU
// loads/stores onto one memory port with a single access in flight,
// LSU-first alternating priority, and routes each response to its owner.
// Optional abort timer: define YSYX_25020047_MEM_ARB_TIMEOUT_EN.
module ysyx_25020047_mem_arb
    import ysyx_25020047_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e      state_q;
    owner_e      owner_q;
    logic        last_lsu_q;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic        mem_req_valid_q;

    logic grant_lsu;
    logic accept;
    logic in_flight;
    logic mem_done;
    logic timeout_hit;
    logic resp_fire;

    // Arbitrate in IDLE and decode completion of the in-flight access.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        grant_lsu     = 1'b0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        if (state_q == ST_IDLE) begin
            // LSU wins a tie unless it won the previous grant.
            grant_lsu     = lsu_req_valid && (!ifu_req_valid || !last_lsu_q);
            lsu_req_ready = grant_lsu;
            ifu_req_ready = ifu_req_valid && !grant_lsu;
        end
        accept    = ifu_req_ready || lsu_req_ready;
        in_flight = (state_q == ST_REQ) || (state_q == ST_WAIT);
        mem_done  = (state_q == ST_WAIT) && mem_resp_valid;
    end

`ifdef YSYX_25020047_MEM_ARB_TIMEOUT_EN
    logic timer_expired;
    logic err_q;

    ysyx_25020047_mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .active (in_flight),
        .expired(timer_expired)
    );

    // A real response in the expiry cycle completes normally.
    assign timeout_hit = in_flight && timer_expired && !mem_done;

    // Sticky error: set by an abort, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Control FSM: latch the granted request, present it, await the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the latched request fields are reset too, so the memory
            // port shows known zeros until the first grant.
            state_q         <= ST_IDLE;
            owner_q         <= OWNER_IFU;
            last_lsu_q      <= 1'b0;
            wen_q           <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            mem_req_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q         <= ST_REQ;
                        mem_req_valid_q <= 1'b1;
                        if (lsu_req_ready) begin
                            owner_q    <= OWNER_LSU;
                            last_lsu_q <= 1'b1;
                            wen_q      <= lsu_wen;
                            addr_q     <= lsu_addr;
                            wdata_q    <= lsu_wdata;
                            wmask_q    <= lsu_wmask;
                        end else begin
                            owner_q    <= OWNER_IFU;
                            last_lsu_q <= 1'b0;
                            wen_q      <= 1'b0;
                            addr_q     <= ifu_addr;
                            wdata_q    <= '0;
                            wmask_q    <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (timeout_hit) begin
                        state_q         <= ST_IDLE;
                        mem_req_valid_q <= 1'b0;
                    end else if (mem_req_ready) begin
                        state_q         <= ST_WAIT;
                        mem_req_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (resp_fire) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    mem_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_wen       = wen_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    // Route the completion (real or aborted) to the owner; aborts and store
    // acks return zero data.
    always_comb begin
        resp_fire      = mem_done || timeout_hit;
        ifu_resp_valid = resp_fire && (owner_q == OWNER_IFU);
        lsu_resp_valid = resp_fire && (owner_q == OWNER_LSU);
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        if (ifu_resp_valid && mem_done) begin
            ifu_rdata = mem_rdata;
        end
        if (lsu_resp_valid && mem_done && !wen_q) begin
            lsu_rdata = mem_rdata;
        end
    end

endmodule
